// File: rtl/mem_access_fsm_if.sv
// BRAM-side bus of mem_access_fsm: both ports of a dual-port synchronous BRAM.
// The controller is the master (drives address/data/we and reads q).
// The memory is the slave.
interface mem_access_fsm_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) ();
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] data_a;
   logic [DATA_WIDTH-1:0] data_b;
   logic                  we_a;
   logic                  we_b;
   logic [DATA_WIDTH-1:0] q_a;
   logic [DATA_WIDTH-1:0] q_b;

   modport master (
      output addr_a, addr_b, data_a, data_b, we_a, we_b,
      input  q_a, q_b
   );

   modport slave (
      input  addr_a, addr_b, data_a, data_b, we_a, we_b,
      output q_a, q_b
   );
endinterface

// File: rtl/mem_access_fsm.sv
// Single/burst read-write controller for one port of a dual-port BRAM.
// Modes: single read, single write, fill (incrementing pattern) and check
// (compare against the same pattern, stop at the first mismatch).
// Every output is registered. busy/done lag the state by one clock, so the
// first word's we pulse appears one cycle after the start edge is sampled.
module mem_access_fsm #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic                  port_sel,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] count,
   mem_access_fsm_if.master      bram,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] last_wdata,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic                  port_led,
   output logic                  rw_led
);
   localparam logic [1:0] MODE_CHECK = 2'b11;
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} stateT;

   stateT                 state;
   logic                  startPrev;
   logic [1:0]            modeLat;
   logic                  portLat;
   logic [ADDR_WIDTH-1:0] baseLat;
   logic [DATA_WIDTH-1:0] wdataLat;
   logic [ADDR_WIDTH-1:0] remaining;
   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] addrA, addrB;
   logic [DATA_WIDTH-1:0] dataA, dataB;
   logic                  weA, weB;

   logic [ADDR_WIDTH-1:0] curAddr;
   logic [DATA_WIDTH-1:0] expData;
   logic [DATA_WIDTH-1:0] selQ;
   logic                  startEdge;
   logic                  isWrite;
   logic                  isBurst;
   logic                  lastWord;

   // Address and pattern both wrap naturally through their widths.
   assign curAddr   = baseLat + offset;
   assign expData   = wdataLat + DATA_WIDTH'(offset);
   assign selQ      = portLat ? bram.q_b : bram.q_a;
   assign startEdge = start & ~startPrev;
   assign isWrite   = modeLat[1] ^ modeLat[0];   // single write or fill
   assign isBurst   = modeLat[1];                // fill or check
   assign lastWord  = !isBurst || (remaining == ONE);

   assign bram.addr_a = addrA;
   assign bram.addr_b = addrB;
   assign bram.data_a = dataA;
   assign bram.data_b = dataB;
   assign bram.we_a   = weA;
   assign bram.we_b   = weB;

   // Transaction sequencer. It also registers every output and all the bus signals.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         startPrev  <= 1'b0;
         modeLat    <= '0;
         portLat    <= 1'b0;
         baseLat    <= '0;
         wdataLat   <= '0;
         remaining  <= '0;
         offset     <= '0;
         addrA      <= '0;
         addrB      <= '0;
         dataA      <= '0;
         dataB      <= '0;
         weA        <= 1'b0;
         weB        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rdata      <= '0;
         last_wdata <= '0;
         error      <= 1'b0;
         err_addr   <= '0;
         port_led   <= 1'b0;
         rw_led     <= 1'b0;
      end else begin
         startPrev <= start;
         weA       <= 1'b0;
         weB       <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (startEdge) begin
                  modeLat   <= mode;
                  portLat   <= port_sel;
                  baseLat   <= base_addr;
                  wdataLat  <= wdata;
                  remaining <= count;
                  offset    <= '0;
                  error     <= 1'b0;
                  err_addr  <= '0;
                  port_led  <= port_sel;
                  rw_led    <= mode[1] ^ mode[0];
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               busy <= 1'b1;
               if (isBurst && remaining == '0) begin
                  // An empty burst touches no memory at all.
                  state <= DONE;
               end else begin
                  if (portLat) addrB <= curAddr;
                  else         addrA <= curAddr;
                  if (isWrite) begin
                     if (portLat) begin
                        weB   <= 1'b1;
                        dataB <= expData;
                     end else begin
                        weA   <= 1'b1;
                        dataA <= expData;
                     end
                     last_wdata <= expData;
                     offset     <= offset + ONE;
                     remaining  <= remaining - ONE;
                     state      <= lastWord ? DONE : ISSUE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // The address is held here while the BRAM registers q.
               busy  <= 1'b1;
               state <= CAPTURE;
            end
            CAPTURE: begin
               busy  <= 1'b1;
               rdata <= selQ;
               if (modeLat == MODE_CHECK && selQ != expData) begin
                  error    <= 1'b1;
                  err_addr <= curAddr;
                  state    <= DONE;
               end else begin
                  offset    <= offset + ONE;
                  remaining <= remaining - ONE;
                  state     <= lastWord ? DONE : ISSUE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_fsm.sv
// Directed bench for mem_access_fsm with a behavioural dual-port BRAM.
// The k-th trace sample is taken at the falling edge after the k-th rising
// edge. Edge 0 is the one that samples the start rising edge.
module tb_mem_access_fsm;
   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int TRACE = 16;

   logic          clk      = 1'b0;
   logic          reset_n  = 1'b1;
   logic          start    = 1'b0;
   logic [1:0]    mode     = 2'b00;
   logic          portSel  = 1'b0;
   logic [AW-1:0] baseAddr = '0;
   logic [DW-1:0] wdata    = '0;
   logic [AW-1:0] count    = '0;
   logic          busy, done, error, portLed, rwLed;
   logic [DW-1:0] rdata, lastWdata;
   logic [AW-1:0] errAddr;

   logic          corruptReq  = 1'b0;
   logic [AW-1:0] corruptAddr = '0;
   logic [DW-1:0] corruptData = '0;

   mem_access_fsm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bram ();

   mem_access_fsm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .port_sel(portSel), .base_addr(baseAddr), .wdata(wdata), .count(count),
      .bram(bram), .busy(busy), .done(done), .rdata(rdata),
      .last_wdata(lastWdata), .error(error), .err_addr(errAddr),
      .port_led(portLed), .rw_led(rwLed)
   );

   always #5 clk = ~clk;

   // Shared-array dual-port BRAM, read-first, q one clock after address.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bram.we_a) mem[bram.addr_a] <= bram.data_a;
      if (bram.we_b) mem[bram.addr_b] <= bram.data_b;
      if (corruptReq) mem[corruptAddr] <= corruptData;
      bram.q_a <= mem[bram.addr_a];
      bram.q_b <= mem[bram.addr_b];
   end

   int checkCnt = 0;
   int errCnt   = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [TRACE-1:0] weAT, weBT, busyT;
   logic [AW-1:0]    addrAT [TRACE];
   logic [AW-1:0]    addrBT [TRACE];
   logic [DW-1:0]    dataAT [TRACE];
   int               doneAt, doneCnt;
   logic [DW-1:0]    rdataAtDone;
   bit               sawAddr1;

   // Launches one transaction, then scrambles the inputs to show they are latched.
   // With toggle=1, start drops while busy, rises again and stays high through DONE.
   task automatic runTxn(input logic [1:0] m, input logic ps, input logic [AW-1:0] ba,
                         input logic [DW-1:0] wd, input logic [AW-1:0] cnt, input bit toggle);
      @(negedge clk);
      mode = m; portSel = ps; baseAddr = ba; wdata = wd; count = cnt; start = 1'b1;
      doneAt = -1; doneCnt = 0; sawAddr1 = 1'b0; rdataAtDone = '0;
      weAT = '0; weBT = '0; busyT = '0;
      @(posedge clk);
      for (int k = 0; k < TRACE; k++) begin
         @(negedge clk);
         weAT[k]   = bram.we_a;
         weBT[k]   = bram.we_b;
         busyT[k]  = busy;
         addrAT[k] = bram.addr_a;
         addrBT[k] = bram.addr_b;
         dataAT[k] = bram.data_a;
         if (k >= 1 && bram.addr_a == AW'(1)) sawAddr1 = 1'b1;
         if (done) begin
            doneCnt++;
            if (doneAt < 0) begin
               doneAt      = k;
               rdataAtDone = rdata;
            end
         end
         if (k == 0) begin
            mode = ~m; portSel = ~ps; baseAddr = ~ba; wdata = ~wd; count = ~cnt;
            if (!toggle) start = 1'b0;
         end
         if (toggle && k == 1) start = 1'b0;
         if (toggle && k == 2) start = 1'b1;
      end
      start = 1'b0;
   endtask

   // Overall time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int wePulses, donePulses;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checkVal("rst_busy",   busy, 0);
      checkVal("rst_done",   done, 0);
      checkVal("rst_we_a",   bram.we_a, 0);
      checkVal("rst_addr_a", bram.addr_a, 0);
      checkVal("rst_rdata",  rdata, 0);
      checkVal("rst_error",  error, 0);
      checkVal("rst_leds",   {portLed, rwLed}, 0);
      reset_n = 1'b1;

      // Single write, port A.
      runTxn(2'b01, 1'b0, 4'd3, 16'hBEEF, 4'd9, 1'b0);
      checkVal("sw_we_a",    weAT, 16'h0002);
      checkVal("sw_we_b",    weBT, 16'h0000);
      checkVal("sw_addr",    addrAT[1], 3);
      checkVal("sw_data",    dataAT[1], 16'hBEEF);
      checkVal("sw_done_at", doneAt, 2);
      checkVal("sw_leds",    {portLed, rwLed}, 2'b01);
      checkVal("sw_lastw",   lastWdata, 16'hBEEF);

      // Single read, port B, same address.
      runTxn(2'b00, 1'b1, 4'd3, 16'h0000, 4'd0, 1'b0);
      checkVal("sr_addr_b",  addrBT[1], 3);
      checkVal("sr_done_at", doneAt, 4);
      checkVal("sr_rdata",   rdataAtDone, 16'hBEEF);
      checkVal("sr_busy",    busyT, 16'h000E);
      checkVal("sr_we_b",    weBT, 16'h0000);
      checkVal("sr_a_hold",  addrAT[4], 3);
      checkVal("sr_leds",    {portLed, rwLed}, 2'b10);

      // Fill port A across the address wrap.
      runTxn(2'b10, 1'b0, 4'd14, 16'h0010, 4'd4, 1'b0);
      checkVal("fill_we_a",  weAT, 16'h001E);
      for (int i = 1; i <= 4; i++) begin
         checkVal($sformatf("fill_addr%0d", i), addrAT[i], 32'((14 + i - 1) % 16));
         checkVal($sformatf("fill_data%0d", i), dataAT[i], 32'(16'h0010 + i - 1));
      end
      checkVal("fill_done_at", doneAt, 5);
      checkVal("fill_lastw",   lastWdata, 16'h0013);

      // Corrupt location 0, then check the same range.
      @(negedge clk);
      corruptReq = 1'b1; corruptAddr = 4'd0; corruptData = 16'hFFFF;
      @(negedge clk);
      corruptReq = 1'b0;
      runTxn(2'b11, 1'b0, 4'd14, 16'h0010, 4'd4, 1'b0);
      checkVal("chk_error",    error, 1);
      checkVal("chk_err_addr", errAddr, 0);
      checkVal("chk_done_at",  doneAt, 10);
      checkVal("chk_no_addr1", sawAddr1, 0);
      checkVal("chk_no_we",    weAT, 16'h0000);
      checkVal("chk_rdata",    rdata, 16'hFFFF);

      // The next start clears the error.
      runTxn(2'b00, 1'b0, 4'd15, 16'h0000, 4'd0, 1'b0);
      checkVal("clr_error",   error, 0);
      checkVal("clr_rdata",   rdataAtDone, 16'h0011);
      checkVal("clr_done_at", doneAt, 4);

      // Start toggled while busy and held through DONE: only one transaction.
      runTxn(2'b10, 1'b1, 4'd5, 16'h1234, 4'd2, 1'b1);
      checkVal("tog_done_cnt", doneCnt, 1);
      checkVal("tog_done_at",  doneAt, 3);
      checkVal("tog_we_b",     weBT, 16'h0006);
      checkVal("tog_busy",     busyT, 16'h0006);
      checkVal("tog_lastw",    lastWdata, 16'h1235);

      // Empty fill: done at cycle 2, no writes, last_wdata untouched.
      runTxn(2'b10, 1'b0, 4'd7, 16'h5555, 4'd0, 1'b0);
      checkVal("fill0_done_at", doneAt, 2);
      checkVal("fill0_we",      {weAT, weBT}, 0);
      checkVal("fill0_lastw",   lastWdata, 16'h1235);

      // Reset during the third word of a fill.
      @(negedge clk);
      mode = 2'b10; portSel = 1'b0; baseAddr = 4'd2; wdata = 16'h0100; count = 4'd6; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("rmb_pre_we",   bram.we_a, 1);
      checkVal("rmb_pre_addr", bram.addr_a, 4);
      #1 reset_n = 1'b0;
      #1;
      checkVal("rmb_we_a",  bram.we_a, 0);
      checkVal("rmb_busy",  busy, 0);
      checkVal("rmb_addr",  bram.addr_a, 0);
      checkVal("rmb_data",  bram.data_a, 0);
      checkVal("rmb_lastw", lastWdata, 0);
      checkVal("rmb_leds",  {portLed, rwLed}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wePulses = 0; donePulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bram.we_a || bram.we_b) wePulses++;
         if (done) donePulses++;
      end
      checkVal("rmb_no_we",   wePulses, 0);
      checkVal("rmb_no_done", donePulses, 0);

      $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
      $finish;
   end
endmodule

// File: doc/mem_access_fsm.md
Name: mem_access_fsm

Overview:
- Parametrised controller that runs single and burst read/write transactions against one port (A or B) of the team's dual-port synchronous BRAM, selected per transaction.
- Adds to single read/write: fill and check burst modes, first-mismatch reporting, and a busy/done handshake.
- Sits between board I/O (switches, debounced buttons, 7-seg drivers) and the bram instance; the BRAM itself is external to this block.

Parameters:
- DATA_WIDTH, 16, word width of BRAM data.
- ADDR_WIDTH, 16, BRAM address width; address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level request, already synchronized; rising edge (registered previous value) launches a transaction.
- mode  in  2  00 single read, 01 single write, 10 fill, 11 check.
- port_sel  in  1  0 = port A, 1 = port B.
- base_addr  in  ADDR_WIDTH  first address.
- wdata  in  DATA_WIDTH  write data / pattern seed.
- count  in  ADDR_WIDTH  burst word count (fill/check only).
- addr_a, addr_b  out  ADDR_WIDTH  BRAM addresses.
- data_a, data_b  out  DATA_WIDTH  BRAM write data.
- we_a, we_b  out  1  BRAM write enables.
- q_a, q_b  in  DATA_WIDTH  BRAM read data, valid one clock after address.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  last captured read word.
- last_wdata  out  DATA_WIDTH  last written word.
- error  out  1  check-mode mismatch flag.
- err_addr  out  ADDR_WIDTH  address of first mismatch.
- port_led, rw_led  out  1  latched port_sel; 1 when latched mode is write or fill.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, including we_a/we_b, addresses, data, rdata, last_wdata, error, err_addr, LEDs and the start-edge register.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: on a start rising edge, latch mode, port_sel, base_addr, wdata and count. Set offset=0, clear error and err_addr, go to ISSUE. Start edges outside IDLE are ignored; inputs are not re-sampled mid-transaction.
- ISSUE:
  - Drive selected-port address = base_addr+offset (wraps).
  - Write modes: we=1 for exactly this cycle, data = wdata+offset (modulo 2^DATA_WIDTH); last_wdata updated.
  - Read modes: we=0, go to WAIT.
- WAIT: address held; BRAM registers q on this edge. Go to CAPTURE.
- CAPTURE: rdata <= selected q. Check mode compares q with wdata+offset; on the first mismatch set error=1, err_addr=current address, then go to DONE (stop on first mismatch).
- Advance rule: after a word completes (ISSUE for writes, CAPTURE for reads), offset increments. Go to ISSUE if the remaining count is >0, else DONE. Single modes perform exactly one word, ignoring count.
- Burst count: fill/check with count=0 performs no BRAM access; ISSUE goes straight to DONE with no we pulse.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy: 1 in ISSUE, WAIT and CAPTURE; 0 otherwise.
- Latency from the start edge sampled at cycle 0:
  - single write: we at cycle 1, done at cycle 2.
  - single read: rdata valid and done at cycle 4.
  - fill of N words: N we pulses on consecutive cycles 1..N, done at N+1.
  - check of N words: 3 cycles per word, done at 3N+1 if there is no mismatch.
- Unselected port: we=0 always; its address and data hold their previous values.
- Holds: error, err_addr, rdata and last_wdata hold until the next accepted start (error and err_addr clear there; rdata and last_wdata update only on access).
- Reset mid-burst: abort immediately, all outputs to reset values; no further we pulses.

Test Plan:
- Reset, then single write port A (DW=16, AW=4), addr=3, wdata=16'hBEEF -> we_a=1 at cycle 1 only, addr_a=3, data_a=BEEF, we_b=0 throughout, done at cycle 2, rw_led=1, port_led=0.
- Single read port B, addr=3, BRAM model holding BEEF -> addr_b=3 from cycle 1, rdata=BEEF and done at cycle 4, busy high for cycles 1-3.
- Fill port A, base=14, count=4, wdata=0010 -> writes 0010@14, 0011@15, 0012@0, 0013@1 on cycles 1-4; done at cycle 5.
- Check same range with location 0 corrupted to FFFF -> error=1, err_addr=0, done right after the third word's CAPTURE, no read of address 1; the next start clears error.
- Start toggled while busy, then held high through DONE -> ignored, no second transaction; fill with count=0 -> done at cycle 2, no we pulses.
- reset_n low during the third word of a fill -> we_a drops immediately, busy=0, done never pulses, outputs zero.
